// File: rtl/autoconfig_responder.sv
// Zorro II AutoConfig responder offering 2MB FastRAM blocks and driving the DRAM bank enables.
// Optional FALLBACK_8M_EN: offer one 8MB block first and fall back to 2MB blocks on shutup.
`timescale 1ns/1ps
module autoconfig_responder #(
  parameter logic [15:0] MFG_ID     = 16'h07DB,
  parameter logic [7:0]  PROD_ID    = 8'd69,
  parameter logic [15:0] SERIAL     = 16'd421,
  parameter int          NUM_BLOCKS = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        ASn,
  input  logic        UDSn,
  input  logic        RWn,
  input  logic        CFGINn,
  input  logic [23:1] ADDR,
  input  logic [3:0]  DBUS_IN,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  output logic        CFGOUTn,
  output logic [7:0]  BANK_EN,
  output logic        CONFIGURED
);

  typedef enum logic [1:0] {WAIT, OFFER, DONE, SHUTUP} state_t;

`ifdef FALLBACK_8M_EN
  localparam logic [2:0] LAST_BLK = 3'(NUM_BLOCKS);
`else
  localparam logic [2:0] LAST_BLK = 3'(NUM_BLOCKS - 1);
`endif

  state_t      state, state_nx;
  logic [2:0]  blk, blk_nx;
  logic [7:0]  bank_en, bank_nx;
  logic        configured, cfg_nx;
  logic        cfgin_r, cfgout_n;
  logic [3:0]  dbus_out, rd_nibble;
  logic [2:0]  as_s, uds_s;
  logic [1:0]  cfgin_s;
  logic        as_rise, wr_strobe, window;
  logic [7:0]  reg_idx;
  logic        unused_addr;

  assign unused_addr = ^ADDR[15:9];
  assign reg_idx     = ADDR[8:1];

  // Index 1 is the synchronised level, index 2 the previous one for edge detection.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      as_s    <= 3'b111;
      uds_s   <= 3'b111;
      cfgin_s <= 2'b11;
    end else begin
      as_s    <= {as_s[1:0], ASn};
      uds_s   <= {uds_s[1:0], UDSn};
      cfgin_s <= {cfgin_s[0], CFGINn};
    end
  end

  assign as_rise   = as_s[1] & ~as_s[2];
  assign wr_strobe = ~uds_s[1] & uds_s[2] & ~as_s[1] & ~RWn;
  assign window    = (ADDR[23:16] == 8'hE8) && !cfgin_r &&
                     (state == WAIT || state == OFFER);

  always_comb begin
    rd_nibble = 4'hF;
    case (reg_idx)
      8'h00: rd_nibble = 4'hE;
`ifdef FALLBACK_8M_EN
      8'h01: rd_nibble = (blk == 3'd0) ? 4'h0 : 4'h6;
`else
      8'h01: rd_nibble = 4'h6;
`endif
      8'h02: rd_nibble = ~PROD_ID[7:4];
      8'h03: rd_nibble = ~PROD_ID[3:0];
      8'h04: rd_nibble = ~4'h8;
      8'h05: rd_nibble = ~4'h0;
      8'h08: rd_nibble = ~MFG_ID[15:12];
      8'h09: rd_nibble = ~MFG_ID[11:8];
      8'h0A: rd_nibble = ~MFG_ID[7:4];
      8'h0B: rd_nibble = ~MFG_ID[3:0];
      8'h0C: rd_nibble = ~SERIAL[15:12];
      8'h0D: rd_nibble = ~SERIAL[11:8];
      8'h0E: rd_nibble = ~SERIAL[7:4];
      8'h0F: rd_nibble = ~SERIAL[3:0];
      8'h20, 8'h21: rd_nibble = 4'h0;
      default: rd_nibble = 4'hF;
    endcase
  end

  // Offer sequencing: a base write always consumes the current offer, valid nibble or not.
  always_comb begin
    state_nx = state;
    blk_nx   = blk;
    bank_nx  = bank_en;
    cfg_nx   = configured;
    if (state == WAIT && !cfgin_r)
      state_nx = OFFER;
    if (wr_strobe && window) begin
      if (reg_idx == 8'h24) begin
`ifdef FALLBACK_8M_EN
        if (blk == 3'd0) begin
          if (DBUS_IN == 4'h2) begin
            bank_nx = 8'hFF;
            cfg_nx  = 1'b1;
          end
          state_nx = DONE;
        end else begin
`endif
          case (DBUS_IN)
            4'h2: begin bank_nx[1:0] = 2'b11; cfg_nx = 1'b1; end
            4'h4: begin bank_nx[3:2] = 2'b11; cfg_nx = 1'b1; end
            4'h6: begin bank_nx[5:4] = 2'b11; cfg_nx = 1'b1; end
            4'h8: begin bank_nx[7:6] = 2'b11; cfg_nx = 1'b1; end
            default: ;
          endcase
          if (blk < LAST_BLK) begin
            blk_nx   = blk + 3'd1;
            state_nx = OFFER;
          end else begin
            state_nx = DONE;
          end
`ifdef FALLBACK_8M_EN
        end
`endif
      end else if (reg_idx == 8'h26) begin
`ifdef FALLBACK_8M_EN
        if (blk == 3'd0) begin
          blk_nx   = 3'd1;
          state_nx = OFFER;
        end else begin
          state_nx = SHUTUP;
        end
`else
        state_nx = SHUTUP;
`endif
      end
    end
  end

  // CFGOUTn and the sampled CFGINn only move at the end of a bus cycle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= WAIT;
      blk        <= 3'd0;
      bank_en    <= 8'h00;
      configured <= 1'b0;
      cfgin_r    <= 1'b1;
      cfgout_n   <= 1'b1;
      dbus_out   <= 4'hF;
    end else begin
      state      <= state_nx;
      blk        <= blk_nx;
      bank_en    <= bank_nx;
      configured <= cfg_nx;
      if (as_rise) begin
        cfgin_r  <= cfgin_s[1];
        cfgout_n <= !(state == DONE || state == SHUTUP);
      end
      if (window && RWn)
        dbus_out <= rd_nibble;
    end
  end

  assign DBUS_OUT   = dbus_out;
  assign DBUS_OE    = RESETn & window & RWn & ~ASn & ~UDSn;
  assign CFGOUTn    = cfgout_n;
  assign BANK_EN    = bank_en;
  assign CONFIGURED = configured;

endmodule

// File: tb/tb_autoconfig_responder.sv
// Randomised bench for autoconfig_responder against a behavioural AutoConfig model.
`timescale 1ns/1ps
module tb_autoconfig_responder;

  localparam logic [15:0] MFG_ID     = 16'h07DB;
  localparam logic [7:0]  PROD_ID    = 8'd69;
  localparam logic [15:0] SERIAL     = 16'd421;
  localparam int          NUM_BLOCKS = 4;

  logic        CLK = 1'b0;
  logic        RESETn, ASn, UDSn, RWn, CFGINn;
  logic [23:1] ADDR;
  logic [3:0]  DBUS_IN;
  logic [3:0]  DBUS_OUT;
  logic        DBUS_OE, CFGOUTn, CONFIGURED;
  logic [7:0]  BANK_EN;

  autoconfig_responder #(
    .MFG_ID(MFG_ID), .PROD_ID(PROD_ID), .SERIAL(SERIAL), .NUM_BLOCKS(NUM_BLOCKS)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .UDSn(UDSn), .RWn(RWn), .CFGINn(CFGINn),
    .ADDR(ADDR), .DBUS_IN(DBUS_IN), .DBUS_OUT(DBUS_OUT), .DBUS_OE(DBUS_OE),
    .CFGOUTn(CFGOUTn), .BANK_EN(BANK_EN), .CONFIGURED(CONFIGURED)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         steady   = 0;
  logic [7:0] m_bank;
  bit         m_conf, m_cfgout, m_cfgin, m_open, m_mode8;
  int         m_offers;
  logic [3:0] last_rd;

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Board-level view: what a correctly behaving card shows in config register space.
  function automatic logic [3:0] exp_rd(input logic [7:0] idx);
    logic [3:0] v;
    v = 4'hF;
    case (idx)
      8'h00: v = 4'hE;
      8'h01: v = m_mode8 ? 4'h0 : 4'h6;
      8'h02: v = ~PROD_ID[7:4];
      8'h03: v = ~PROD_ID[3:0];
      8'h04: v = 4'h7;
      8'h08: v = ~MFG_ID[15:12];
      8'h09: v = ~MFG_ID[11:8];
      8'h0A: v = ~MFG_ID[7:4];
      8'h0B: v = ~MFG_ID[3:0];
      8'h0C: v = ~SERIAL[15:12];
      8'h0D: v = ~SERIAL[11:8];
      8'h0E: v = ~SERIAL[7:4];
      8'h0F: v = ~SERIAL[3:0];
      8'h20, 8'h21: v = 4'h0;
      default: v = 4'hF;
    endcase
    return v;
  endfunction

  function automatic void model_reset();
    m_bank   = 8'h00;
    m_conf   = 0;
    m_cfgout = 1;
    m_cfgin  = 1;
    m_open   = 1;
    m_offers = NUM_BLOCKS;
`ifdef FALLBACK_8M_EN
    m_mode8  = 1;
`else
    m_mode8  = 0;
`endif
  endfunction

  function automatic void model_write(input logic [7:0] idx, input logic [3:0] d);
    if (idx == 8'h24) begin
      if (m_mode8) begin
        if (d == 4'h2) begin m_bank = 8'hFF; m_conf = 1; end
        m_open = 0;
      end else begin
        if (d == 4'h2 || d == 4'h4 || d == 4'h6 || d == 4'h8) begin
          m_bank = m_bank | (8'h03 << (d - 4'd2));
          m_conf = 1;
        end
        m_offers = m_offers - 1;
        if (m_offers == 0) m_open = 0;
      end
    end else if (idx == 8'h26) begin
      if (m_mode8) begin
        m_mode8  = 0;
        m_offers = NUM_BLOCKS;
      end else begin
        m_open = 0;
      end
    end
  endfunction

  always @(negedge CLK) begin
    if (steady) begin
      checkOutput("bank_en", 32'(BANK_EN), 32'(m_bank));
      checkOutput("configured", 32'(CONFIGURED), 32'(m_conf));
      checkOutput("cfgoutn", 32'(CFGOUTn), 32'(m_cfgout));
      checkOutput("dbus_oe_idle", 32'(DBUS_OE), 32'd0);
    end
  end

  // One complete 68000 bus cycle at byte address a.
  task applyStimulus(input logic [23:0] a, input bit rd, input logic [3:0] d);
    bit exp_win;
    ADDR    = a[23:1];
    RWn     = rd;
    DBUS_IN = d;
    exp_win = (a[23:16] == 8'hE8) && !m_cfgin && m_open;
    repeat (2) @(posedge CLK);
    #1 steady = 0;
    ASn = 0;
    repeat (2) @(posedge CLK);
    #1 checkOutput("oe_before_uds", 32'(DBUS_OE), 32'd0);
    UDSn = 0;
    #1 checkOutput("oe_during_uds", 32'(DBUS_OE), 32'(exp_win && rd));
    repeat (4) @(posedge CLK);
    #1 last_rd = DBUS_OUT;
    if (rd && exp_win) checkOutput("dbus_out", 32'(DBUS_OUT), 32'(exp_rd(a[8:1])));
    checkOutput("cfgout_hold", 32'(CFGOUTn), 32'(m_cfgout));
    UDSn = 1;
    ASn  = 1;
    RWn  = 1;
    #1 checkOutput("oe_after", 32'(DBUS_OE), 32'd0);
    if (!rd && exp_win) model_write(a[8:1], d);
    m_cfgin  = CFGINn;
    m_cfgout = m_open;
    repeat (5) @(posedge CLK);
    #1 steady = 1;
  endtask

  // Asynchronous reset, asserted off the clock edge, possibly in the middle of a bus cycle.
  task doReset();
    steady = 0;
    @(posedge CLK);
    #3 RESETn = 0;
    #1;
    checkOutput("rst_oe", 32'(DBUS_OE), 32'd0);
    checkOutput("rst_bank", 32'(BANK_EN), 32'd0);
    checkOutput("rst_conf", 32'(CONFIGURED), 32'd0);
    checkOutput("rst_cfgout", 32'(CFGOUTn), 32'd1);
    checkOutput("rst_dbus_out", 32'(DBUS_OUT), 32'hF);
    ASn  = 1;
    UDSn = 1;
    RWn  = 1;
    model_reset();
    repeat (3) @(posedge CLK);
    #3 RESETn = 1;
    repeat (2) @(posedge CLK);
    #1 steady = 1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int op;
    logic [7:0] idx;
    logic [3:0] nib;
    RESETn = 1; ASn = 1; UDSn = 1; RWn = 1; CFGINn = 0;
    ADDR = '0; DBUS_IN = 4'h0;
    model_reset();

    // Identification reads with hand-computed nibbles.
    doReset();
    CFGINn = 0;
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE80000, 1, 4'h0); checkOutput("pin_00", 32'(last_rd), 32'hE);
`ifdef FALLBACK_8M_EN
    applyStimulus(24'hE80002, 1, 4'h0); checkOutput("pin_02_8m", 32'(last_rd), 32'h0);
`else
    applyStimulus(24'hE80002, 1, 4'h0); checkOutput("pin_02", 32'(last_rd), 32'h6);
`endif
    applyStimulus(24'hE80010, 1, 4'h0); checkOutput("pin_10", 32'(last_rd), 32'hF);
    applyStimulus(24'hE80004, 1, 4'h0); checkOutput("pin_04", 32'(last_rd), 32'hB);
    applyStimulus(24'hE80006, 1, 4'h0); checkOutput("pin_06", 32'(last_rd), 32'hA);
    applyStimulus(24'hE80008, 1, 4'h0); checkOutput("pin_08", 32'(last_rd), 32'h7);
    applyStimulus(24'hE80014, 1, 4'h0); checkOutput("pin_14", 32'(last_rd), 32'h2);
    applyStimulus(24'hE8001C, 1, 4'h0); checkOutput("pin_1c", 32'(last_rd), 32'h5);
    applyStimulus(24'hE8001E, 1, 4'h0); checkOutput("pin_1e", 32'(last_rd), 32'hA);
    applyStimulus(24'hE80040, 1, 4'h0); checkOutput("pin_40", 32'(last_rd), 32'h0);
    applyStimulus(24'hE80030, 1, 4'h0); checkOutput("pin_30", 32'(last_rd), 32'hF);

    // Not our turn: window stays closed.
    doReset();
    CFGINn = 1;
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE80000, 1, 4'h0);
    applyStimulus(24'hE80048, 0, 4'h2);
    checkOutput("closed_bank", 32'(BANK_EN), 32'h00);

`ifndef FALLBACK_8M_EN
    // Four blocks placed back to back.
    doReset();
    CFGINn = 0;
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE80048, 0, 4'h2);
    applyStimulus(24'hE80048, 0, 4'h4);
    applyStimulus(24'hE80048, 0, 4'h6);
    checkOutput("cfgout_3rd", 32'(CFGOUTn), 32'd1);
    applyStimulus(24'hE80048, 0, 4'h8);
    checkOutput("full_bank", 32'(BANK_EN), 32'hFF);
    checkOutput("full_conf", 32'(CONFIGURED), 32'd1);
    checkOutput("full_cfgout", 32'(CFGOUTn), 32'd0);
    applyStimulus(24'hE80000, 1, 4'h0);

    // One block then shutup.
    doReset();
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE80048, 0, 4'h4);
    applyStimulus(24'hE8004C, 0, 4'h0);
    checkOutput("shut_bank", 32'(BANK_EN), 32'h0C);
    checkOutput("shut_cfgout", 32'(CFGOUTn), 32'd0);

    // Invalid nibble consumes an offer; the fifth write finds the window closed.
    doReset();
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE80048, 0, 4'hA);
    checkOutput("bad_conf", 32'(CONFIGURED), 32'd0);
    applyStimulus(24'hE80048, 0, 4'h2);
    checkOutput("bad_bank", 32'(BANK_EN), 32'h03);
    checkOutput("bad_conf2", 32'(CONFIGURED), 32'd1);
    applyStimulus(24'hE80048, 0, 4'h2);
    applyStimulus(24'hE80048, 0, 4'h6);
    checkOutput("idem_bank", 32'(BANK_EN), 32'h33);
    applyStimulus(24'hE80048, 0, 4'h8);
    checkOutput("over_bank", 32'(BANK_EN), 32'h33);
`else
    // 8MB offer, fallback to 2MB mode on shutup.
    doReset();
    CFGINn = 0;
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE8004C, 0, 4'h0);
    applyStimulus(24'hE80002, 1, 4'h0); checkOutput("fb_reg01", 32'(last_rd), 32'h6);
    checkOutput("fb_cfgout", 32'(CFGOUTn), 32'd1);
    applyStimulus(24'hE80048, 0, 4'h4);
    checkOutput("fb_bank", 32'(BANK_EN), 32'h0C);
    doReset();
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE80048, 0, 4'h2);
    checkOutput("8m_bank", 32'(BANK_EN), 32'hFF);
    checkOutput("8m_cfgout", 32'(CFGOUTn), 32'd0);
`endif

    // Reset pulse in the middle of a read cycle drops DBUS_OE at once.
    doReset();
    CFGINn = 0;
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE80048, 0, 4'h2);
    ADDR = 23'h740000;
    RWn  = 1;
    steady = 0;
    repeat (2) @(posedge CLK);
    #1 ASn = 0; UDSn = 0;
    #1 checkOutput("mid_oe", 32'(DBUS_OE), 32'd1);
    doReset();
    checkOutput("mid_bank", 32'(BANK_EN), 32'h00);
    applyStimulus(24'h000000, 1, 4'h0);
    applyStimulus(24'hE80002, 1, 4'h0);

    // Random sessions.
    for (int r = 0; r < 20; r++) begin
      doReset();
      CFGINn = ($urandom_range(0, 3) == 0);
      applyStimulus(24'h000000, 1, 4'h0);
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 7) == 0) CFGINn = ~CFGINn;
        op = $urandom_range(0, 6);
        if ($urandom_range(0, 3) == 0) nib = 4'($urandom_range(0, 15));
        else nib = 4'(2 * $urandom_range(1, 4));
        case (op)
          0, 1: applyStimulus(24'hE80048, 0, nib);
          2:    applyStimulus(24'hE8004C, 0, 4'h0);
          3, 4: begin
            idx = 8'($urandom_range(0, 8'h30));
            applyStimulus(24'hE80000 | (24'(idx) << 1), 1, 4'h0);
          end
          5:    applyStimulus(24'hE80044, 0, nib);
          default: applyStimulus(24'hE90048, 0, nib);
        endcase
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/autoconfig_responder.md
Name: autoconfig_responder

Overview:
- Standalone Zorro II AutoConfig responder. It sits directly upstream of the FastRAM DRAM controller.
- It answers the $E80000 configuration window and offers 2MB RAM blocks in sequence.
- It produces the per-1MB bank enable vector and the configured flag that the DRAM controller uses for address decode.
- All bus strobes are synchronised to CLK; there is no strobe-edge clocking.

Parameters:
MFG_ID, 16'h07DB, manufacturer ID returned at $10-$16
PROD_ID, 8'd69, product number returned at $04/$06
SERIAL, 16'd421, serial number returned at $18-$1E (low word)
NUM_BLOCKS, 4, number of 2MB blocks offered (1..4)

Ports:
CLK  in  1  system clock (7.09/7.16MHz)
RESETn  in  1  asynchronous, active-low reset
ASn  in  1  68000 address strobe
UDSn  in  1  upper data strobe
RWn  in  1  read/write, 1=read
CFGINn  in  1  config-in from previous board, 0=our turn
ADDR  in  23  CPU address [23:1]
DBUS_IN  in  4  data bus [15:12] as driven by CPU
DBUS_OUT  out  4  read data nibble for [15:12]
DBUS_OE  out  1  enable for external DBUS[15:12] tristate
CFGOUTn  out  1  config-out to next board
BANK_EN  out  8  bit k enables 1MB bank at $(2+k)00000
CONFIGURED  out  1  at least one base-address write accepted

Behaviour:
- Reset values: DBUS_OUT=4'hF, DBUS_OE=0, CFGOUTn=1, BANK_EN=8'h00, CONFIGURED=0, state=WAIT, blk=0.
- ASn, UDSn and CFGINn each pass through a 2-FF synchroniser on posedge CLK. Edge detects use the synchronised signals.
- as_rise: synced ASn goes 0->1. wr_strobe: synced UDSn goes 1->0 while synced ASn=0 and RWn=0.
- window = (ADDR[23:16]==8'hE8) & cfgin_r==0 & state in {WAIT, OFFER}.
- On each as_rise, cfgin_r <= synced CFGINn. CFGOUTn <= 0 if state in {DONE, SHUTUP}, else 1. CFGOUTn therefore changes only at a bus-cycle end.
- States:
  - WAIT: window closed.
  - OFFER: presenting block blk.
  - DONE: all blocks placed.
  - SHUTUP: told to shut up.
- WAIT->OFFER when cfgin_r=0.
- Read data is registered every CLK while window & RWn, indexed by ADDR[8:1]:
  - 00: 4'hE (Zorro II, memlist, no ROM)
  - 01: 4'h6 (2MB)
  - 02/03: ~PROD_ID nibbles
  - 04: ~4'h8 (memory space)
  - 05: ~4'h0
  - 08-0B: ~MFG_ID nibbles
  - 0C-0F: ~SERIAL nibbles
  - 20/21: 4'h0
  - all others: 4'hF
- DBUS_OE = RESETn & window & RWn & !ASn & !UDSn, using the raw strobes so read data reaches the bus in the same bus cycle.
- wr_strobe with window and ADDR[8:1]==8'h24 (base address, $48): nibble n = DBUS_IN, sampled at wr_strobe.
  - n in {2,4,6,8}: BANK_EN[n-2] and BANK_EN[n-1] set; CONFIGURED <= 1.
  - Any other n: BANK_EN unchanged and CONFIGURED unchanged, but the offer is still consumed.
  - blk < NUM_BLOCKS-1: blk <= blk+1, stay in OFFER.
  - Otherwise: go to DONE.
- wr_strobe with window and ADDR[8:1]==8'h26 (shutup, $4C): go to SHUTUP. BANK_EN keeps any bits already set.
- Writes to other offsets are ignored. Writes outside the window are ignored. A write strobe counts only once per bus cycle, because detection is edge-based.
- BANK_EN bits are sticky until reset. Two writes to the same nibble are idempotent.
- DONE and SHUTUP are terminal until RESETn.
- RESETn asserted mid-cycle: everything returns to reset values immediately, and DBUS_OE drops asynchronously.

Optional Feature:
- Macro: FALLBACK_8M_EN
- Defined:
  - blk=0 offers a single 8MB block: reg 01 returns 4'h0 (8MB), chained=0.
  - Base nibble 2 sets BANK_EN=8'hFF, CONFIGURED=1, then DONE.
  - Any other base nibble consumes the offer without enabling banks, then goes to DONE.
  - Shutup during the 8MB offer does not enter SHUTUP. It enters 2MB mode (blk=1 internally, offering the 2MB sequence of NUM_BLOCKS blocks). CFGOUTn stays high.
  - Shutup in 2MB mode goes to SHUTUP as normal.
- Undefined: 2MB-only offers as described above; the 8MB path and fallback logic are absent.

Test Plan:
- Reset, CFGINn=0, read $E80000/$E80002/$E80010 -> DBUS_OUT 4'hE, 4'h6, ~4'h0=4'hF (MFG_ID[15:12]=0); DBUS_OE asserted only during UDSn low.
- CFGINn=1, read $E80000 -> DBUS_OE stays 0; a write of $2 to $E80048 leaves BANK_EN=8'h00.
- NUM_BLOCKS=4, writes of 2, 4, 6, 8 to $E80048 in four bus cycles -> BANK_EN=8'hFF, CONFIGURED=1, CFGOUTn falls at ASn rise after the 4th write, then window closes (reads give DBUS_OE=0).
- Write 4 to $E80048, then write to $E8004C -> BANK_EN=8'h0C, state SHUTUP, CFGOUTn=0 after that cycle ends.
- Write $A to $E80048 then 2 -> first offer consumed with no banks, BANK_EN=8'h03, CONFIGURED=1.
- FALLBACK_8M_EN: read reg 01 -> 4'h0; write $E8004C, then read reg 01 -> 4'h6 with CFGOUTn=1; pulse RESETn mid-offer -> BANK_EN=0, state WAIT.
